pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of the payload carried through the stage.
REQ-002 SHALL provide parameter BUBBLE_VAL, default '0, payload value loaded on reset/flush (NOP encoding).
REQ-003 SHALL provide parameter CNT_W, default 16, width of the squash counter.
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port flush  input  1  synchronous squash of all held entries (branch/hazard flush).
REQ-007 SHALL provide port in_valid  input  1  upstream payload valid.
REQ-008 SHALL provide port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL provide port in_ready  output  1  stage can accept this cycle.
REQ-010 SHALL provide port out_valid  output  1  downstream payload valid.
REQ-011 SHALL provide port out_data  output  DATA_W  downstream payload.
REQ-012 SHALL provide port out_ready  input  1  downstream accepts (low = stall).
REQ-013 SHALL provide port occupancy  output  2  entries held (0..2).
REQ-014 SHALL provide port squash_cnt  output  CNT_W  count of valid entries discarded by flush.

Function
REQ-015 SHALL hold two entries: main (drives out_*) and skid (overflow); each has a valid bit.
REQ-016 SHALL define accept = in_valid & in_ready, pop = out_valid & out_ready.
REQ-017 SHALL drive in_ready = ~skid_valid, a registered value with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = main_valid and out_data = main_data directly from registers.
REQ-019 SHALL, when main empty or pop: load main from skid if skid_valid (clear skid, then capture accepted input into skid if accept), else from input if accept, else clear main_valid.
REQ-020 SHALL, when main full and no pop and accept: capture input into skid.
REQ-021 SHALL preserve FIFO order; no payload duplicated or dropped absent flush.
REQ-022 SHALL provide latency 1 cycle accept-to-out_valid when empty; throughput 1 payload/cycle when out_ready held high.
REQ-023 SHALL, on flush: clear both valid bits, load both payload registers with BUBBLE_VAL, discard any same-cycle input (accepted handshake is dropped, not stored).
REQ-024 SHALL, on flush, add (main_valid + skid_valid) to squash_cnt, saturating at 2^CNT_W-1; no wrap.
REQ-025 SHALL ignore out_ready during flush cycle; a same-cycle pop is still counted as consumed downstream and not added to squash_cnt.
REQ-026 SHALL drive occupancy = main_valid + skid_valid, registered.
REQ-027 SHALL never present skid_valid=1 with main_valid=0.

Reset
REQ-028 SHALL, on reset, clear main_valid, skid_valid, squash_cnt; load payloads with BUBBLE_VAL; in_ready=1 the following cycle.
REQ-029 SHALL give reset priority over flush and all handshakes; reset mid-stream drops entries without incrementing squash_cnt.

Verification
REQ-030 SHALL verify streaming: out_ready=1, in_valid=1, data 1..8 on consecutive cycles -> out_data 1..8 one cycle later, in_ready constant 1, occupancy<=1.
REQ-031 SHALL verify stall: send A,B,C with out_ready=0 -> A in main, B in skid, in_ready=0 after B, C held upstream; raise out_ready -> A,B,C emerge in order with no gaps.
REQ-032 SHALL verify flush with occupancy 2 and in_valid=1 -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0, squash_cnt+=2, input payload never emerges.
REQ-033 SHALL verify saturation: CNT_W=2, preload squash_cnt=2, flush with 2 held -> squash_cnt=3; further flushes keep 3.
REQ-034 SHALL verify reset during stall with occupancy 2 and flush=1 -> all valids 0, squash_cnt=0, in_ready=1 next cycle.
REQ-035 SHALL verify randomised in_valid/out_ready for 10k cycles against a reference queue model: order preserved, no loss, occupancy matches.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry pipeline register with skid buffer and flush.
//   clk, reset     : single clock, synchronous active-high reset
//   flush          : squash all held entries, same-cycle input dropped
//   in_valid/in_data/in_ready    : upstream handshake (in_ready is registered)
//   out_valid/out_data/out_ready : downstream handshake (driven from registers)
//   occupancy      : entries held (0..2)
//   squash_cnt     : saturating count of valid entries discarded by flush
module pipe_skid_stage #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  squash_cnt
);

  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              pop;
  logic [1:0]        squash_inc;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  cnt_next;

  assign in_ready   = ~skid_valid;
  assign out_valid  = main_valid;
  assign out_data   = main_data;
  assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
  assign squash_cnt = cnt;

  assign accept = in_valid & in_ready;
  assign pop    = main_valid & out_ready;

  // A head entry popped in the flush cycle reached downstream, so only
  // the un-popped entries count as squashed.
  always_comb begin
    squash_inc = {1'b0, main_valid & ~out_ready} + {1'b0, skid_valid};
    cnt_sum    = {1'b0, cnt} + (CNT_W+1)'(squash_inc);
    cnt_next   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= BUBBLE_VAL;
      skid_data  <= BUBBLE_VAL;
      cnt        <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= BUBBLE_VAL;
      skid_data  <= BUBBLE_VAL;
      cnt        <= cnt_next;
    end else if (!main_valid || pop) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= accept;
        if (accept) begin
          skid_data <= in_data;
        end
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int unsigned       DW  = 32;
  localparam int unsigned       CW  = 2;
  localparam logic [DW-1:0]     BUB = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    occupancy;
  logic [CW-1:0] squash_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int m_sq  = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  pipe_skid_stage #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; the expected payload is queued when the handshake will complete.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic rst);
    logic acc;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    acc = v && in_ready && !fl && !rst;
    @(posedge clk);
    if (acc) exp_q.push_back(d);
    #1;
  endtask

  // Monitor: pops expected payloads as the DUT hands them downstream.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_sq = 0;
    end else if (chk_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL pop_unexpected: got %h expected none", out_data);
        end else begin
          check("sb_data", out_data, exp_q.pop_front());
        end
      end
      if (flush) begin
        m_sq = (m_sq + exp_q.size() > 3) ? 3 : m_sq + exp_q.size();
        exp_q.delete();
      end
    end
  end

  // Structural checks against the reference queue, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("occupancy", DW'(occupancy), DW'(exp_q.size()));
      check("in_ready",  DW'(in_ready),  DW'(exp_q.size() < 2));
      check("out_valid", DW'(out_valid), DW'(exp_q.size() != 0));
      check("squash",    DW'(squash_cnt), DW'(m_sq));
    end
  end

  task automatic fill2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    drive(1'b1, a, 1'b0, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0, 1'b0);
    check("fill_occ", DW'(occupancy), 32'd2);
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_out_valid", DW'(out_valid), 32'd0);
    check("rst_in_ready",  DW'(in_ready),  32'd1);
    check("rst_occ",       DW'(occupancy), 32'd0);
    check("rst_squash",    DW'(squash_cnt), 32'd0);
    check("rst_out_data",  out_data, BUB);

    // streaming 1..8 with out_ready high
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      check("stream_data",  out_data, DW'(i));
      check("stream_valid", DW'(out_valid), 32'd1);
      check("stream_ready", DW'(in_ready), 32'd1);
      check("stream_occ",   DW'(occupancy), 32'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("stream_drain", DW'(out_valid), 32'd0);

    // stall: A,B,C with out_ready low
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    check("stall_a_main", out_data, 32'hA);
    check("stall_a_rdy",  DW'(in_ready), 32'd1);
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    check("stall_b_rdy",  DW'(in_ready), 32'd0);
    check("stall_b_occ",  DW'(occupancy), 32'd2);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    check("stall_c_held", DW'(occupancy), 32'd2);
    check("stall_head",   out_data, 32'hA);
    drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    check("release_b",    out_data, 32'hB);
    check("release_rdy",  DW'(in_ready), 32'd1);
    drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    check("release_c",    out_data, 32'hC);
    check("release_cv",   DW'(out_valid), 32'd1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // flush with two held and a same-cycle input
    fill2(32'hD, 32'hE);
    drive(1'b1, 32'hF, 1'b0, 1'b1, 1'b0);
    check("flush_valid",  DW'(out_valid), 32'd0);
    check("flush_bubble", out_data, BUB);
    check("flush_occ",    DW'(occupancy), 32'd0);
    check("flush_squash", DW'(squash_cnt), 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("flush_no_f", DW'(out_valid), 32'd0);
    end

    // saturation at 3 with CNT_W=2
    fill2(32'h11, 32'h12);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("sat_first", DW'(squash_cnt), 32'd3);
    fill2(32'h13, 32'h14);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("sat_hold", DW'(squash_cnt), 32'd3);

    // reset beats flush during a full stall
    fill2(32'h21, 32'h22);
    drive(1'b1, 32'h23, 1'b0, 1'b1, 1'b1);
    check("rstf_valid",  DW'(out_valid), 32'd0);
    check("rstf_occ",    DW'(occupancy), 32'd0);
    check("rstf_squash", DW'(squash_cnt), 32'd0);
    check("rstf_ready",  DW'(in_ready), 32'd1);

    // flush with same-cycle pop: only the skid entry is squashed
    fill2(32'h31, 32'h32);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("popflush_squash", DW'(squash_cnt), 32'd1);
    check("popflush_occ",    DW'(occupancy), 32'd0);

    // randomised traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 63) == 0), 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    check("final_empty", DW'(occupancy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
